// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - MEM/WB pipeline bus carrying the MEM stage's result to writeback
interface writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 7
);
  logic              mem_valid;
  logic [5:0]        mem_opCode;
  logic [ADDR_W-1:0] mem_rd;
  logic              mem_regWrite;
  logic              mem_memToReg;
  logic [1:0]        mem_loadSize;
  logic              mem_loadSigned;
  logic [DATA_W-1:0] mem_aluResult;
  logic [DATA_W-1:0] mem_loadData;
  logic [PC_W-1:0]   mem_linkAddr;

  modport master (
    output mem_valid, mem_opCode, mem_rd, mem_regWrite, mem_memToReg,
           mem_loadSize, mem_loadSigned, mem_aluResult, mem_loadData, mem_linkAddr
  );

  modport slave (
    input  mem_valid, mem_opCode, mem_rd, mem_regWrite, mem_memToReg,
           mem_loadSize, mem_loadSigned, mem_aluResult, mem_loadData, mem_linkAddr
  );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, result select, register-file write port and retire counter
module writeback_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PC_W     = 7,
  parameter int COUNT_W  = 16,
  parameter int LINK_REG = 31
) (
  input  logic               clock,
  input  logic               reset,
  writeback_stage_if.slave   mem,
  input  logic               hold,
  input  logic               flush,
  output logic               regWrite,
  output logic [ADDR_W-1:0]  writeAddr,
  output logic [DATA_W-1:0]  writeData,
  output logic               fwd_valid,
  output logic               misaligned,
  output logic [COUNT_W-1:0] retireCount
);
  localparam logic [5:0] OP_JAL = 6'h03;

  logic              isJal;
  logic              incoming;
  logic [7:0]        laneByte;
  logic [15:0]       laneHalf;
  logic [DATA_W-1:0] loadExt;
  logic [ADDR_W-1:0] nextAddr;
  logic [DATA_W-1:0] nextData;
  logic              nextWrites;
  logic              nextMis;

  logic              valid;
  logic              written;
  logic              writesQ;
  logic              misQ;

  assign isJal    = (mem.mem_opCode == OP_JAL);
  assign incoming = mem.mem_valid & ~flush;

  // Pick the addressed lane out of the aligned memory word and extend it
  always_comb begin
    laneByte = mem.mem_loadData[7:0];
    case (mem.mem_aluResult[1:0])
      2'd1:    laneByte = mem.mem_loadData[15:8];
      2'd2:    laneByte = mem.mem_loadData[23:16];
      2'd3:    laneByte = mem.mem_loadData[31:24];
      default: laneByte = mem.mem_loadData[7:0];
    endcase
    laneHalf = mem.mem_aluResult[1] ? mem.mem_loadData[31:16] : mem.mem_loadData[15:0];
    loadExt  = mem.mem_loadData;
    if (mem.mem_loadSize == 2'b00)
      loadExt = {{(DATA_W-8){mem.mem_loadSigned & laneByte[7]}}, laneByte};
    else if (mem.mem_loadSize == 2'b01)
      loadExt = {{(DATA_W-16){mem.mem_loadSigned & laneHalf[15]}}, laneHalf};
  end

  // Result select: jal link beats load data beats ALU result; size 11 behaves as word
  always_comb begin
    nextAddr   = mem.mem_rd;
    nextData   = mem.mem_aluResult;
    nextWrites = mem.mem_regWrite;
    nextMis    = 1'b0;
    if (isJal) begin
      nextAddr   = ADDR_W'(LINK_REG);
      nextData   = DATA_W'(mem.mem_linkAddr);
      nextWrites = 1'b1;
    end else if (mem.mem_memToReg) begin
      nextData = loadExt;
      nextMis  = ((mem.mem_loadSize == 2'b01) & mem.mem_aluResult[0]) |
                 (mem.mem_loadSize[1] & (mem.mem_aluResult[1:0] != 2'b00));
    end
  end

  // Capture the entry unless held; a held entry is marked written so it never writes twice
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid       <= 1'b0;
      written     <= 1'b1;
      writesQ     <= 1'b0;
      misQ        <= 1'b0;
      writeAddr   <= '0;
      writeData   <= '0;
      retireCount <= '0;
    end else if (!hold) begin
      valid   <= incoming;
      written <= 1'b0;
      if (incoming) begin
        writeAddr   <= nextAddr;
        writeData   <= nextData;
        writesQ     <= nextWrites;
        misQ        <= nextMis;
        retireCount <= retireCount + 1'b1;
      end
    end else begin
      written <= 1'b1;
    end
  end

  assign fwd_valid  = valid & writesQ & ~misQ & (writeAddr != '0);
  assign regWrite   = fwd_valid & ~written;
  assign misaligned = valid & misQ;
endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage with a behavioural reference model
module tb_writeback_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        hold;
  logic        flush;
  logic        regWrite;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        fwd_valid;
  logic        misaligned;
  logic [3:0]  retireCount;

  int errors = 0;
  int checks = 0;

  writeback_stage_if memBus ();

  writeback_stage #(.COUNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem         (memBus),
    .hold        (hold),
    .flush       (flush),
    .regWrite    (regWrite),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .fwd_valid   (fwd_valid),
    .misaligned  (misaligned),
    .retireCount (retireCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pipeline entry described by what it should write
  logic        mValid, mFresh, mWrites, mMis;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  logic [3:0]  mCnt;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mValid = 0; mFresh = 0; mWrites = 0; mMis = 0; mAddr = 0; mData = 0; mCnt = 0;
    end else if (!hold) begin
      mValid = memBus.mem_valid & ~flush;
      mFresh = 1;
      if (mValid) begin
        int unsigned off, v;
        mCnt = mCnt + 4'd1;
        off = memBus.mem_aluResult[1:0];
        mAddr = memBus.mem_rd;
        mWrites = memBus.mem_regWrite;
        mMis = 0;
        mData = memBus.mem_aluResult;
        if (memBus.mem_opCode == 6'h03) begin
          mAddr = 5'd31;
          mData = {25'd0, memBus.mem_linkAddr};
          mWrites = 1;
        end else if (memBus.mem_memToReg) begin
          if (memBus.mem_loadSize == 2'b00) begin
            v = (memBus.mem_loadData >> (8 * off)) & 32'hFF;
            if (memBus.mem_loadSigned && v >= 128) v = v + 32'hFFFF_FF00;
            mData = v;
          end else if (memBus.mem_loadSize == 2'b01) begin
            v = (memBus.mem_loadData >> (off >= 2 ? 16 : 0)) & 32'hFFFF;
            if (memBus.mem_loadSigned && v >= 32768) v = v + 32'hFFFF_0000;
            mData = v;
            mMis = (off % 2) != 0;
          end else begin
            mData = memBus.mem_loadData;
            mMis = off != 0;
          end
        end
      end
    end else begin
      mFresh = 0;
    end
  end

  // Compare every cycle, half a period away from the capturing edge
  always @(negedge clock) begin
    logic expFwd;
    expFwd = mValid & mWrites & ~mMis & (mAddr != 0);
    chk("cyc_regWrite", regWrite, expFwd & mFresh);
    chk("cyc_fwd_valid", fwd_valid, expFwd);
    chk("cyc_misaligned", misaligned, mValid & mMis);
    chk("cyc_retireCount", retireCount, mCnt);
    if (mValid || !reset) begin
      chk("cyc_writeAddr", writeAddr, mAddr);
      chk("cyc_writeData", writeData, mData);
    end
  end

  task automatic issue(input logic v, input logic [5:0] op, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic [1:0] sz, input logic sg,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [6:0] lk,
                       input logic h, input logic f);
    memBus.mem_valid      = v;
    memBus.mem_opCode     = op;
    memBus.mem_rd         = rd;
    memBus.mem_regWrite   = rw;
    memBus.mem_memToReg   = m2r;
    memBus.mem_loadSize   = sz;
    memBus.mem_loadSigned = sg;
    memBus.mem_aluResult  = alu;
    memBus.mem_loadData   = ld;
    memBus.mem_linkAddr   = lk;
    hold  = h;
    flush = f;
    @(posedge clock);
    #1;
  endtask

  task automatic allZero(input string tag);
    chk({tag, "_regWrite"}, regWrite, 0);
    chk({tag, "_writeAddr"}, writeAddr, 0);
    chk({tag, "_writeData"}, writeData, 0);
    chk({tag, "_fwd_valid"}, fwd_valid, 0);
    chk({tag, "_misaligned"}, misaligned, 0);
    chk({tag, "_retireCount"}, retireCount, 0);
  endtask

  initial begin
    reset = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    allZero("reset");
    reset = 1'b1;

    issue(1, 6'h00, 5, 1, 0, 0, 0, 32'h0000_1234, 0, 0, 0, 0);
    chk("alu_regWrite", regWrite, 1);
    chk("alu_writeAddr", writeAddr, 5);
    chk("alu_writeData", writeData, 32'h1234);
    chk("alu_count", retireCount, 1);

    issue(1, 6'h20, 7, 1, 1, 2'b00, 1, 32'h3, 32'h80FF_7F01, 0, 0, 0);
    chk("lb_signed", writeData, 32'hFFFF_FF80);
    issue(1, 6'h24, 7, 1, 1, 2'b00, 0, 32'h3, 32'h80FF_7F01, 0, 0, 0);
    chk("lb_unsigned", writeData, 32'h0000_0080);
    issue(1, 6'h21, 7, 1, 1, 2'b01, 1, 32'h2, 32'h80FF_7F01, 0, 0, 0);
    chk("lh_signed", writeData, 32'hFFFF_80FF);

    issue(1, 6'h03, 9, 0, 0, 0, 0, 32'h0, 0, 7'h2A, 0, 0);
    chk("jal_addr", writeAddr, 31);
    chk("jal_data", writeData, 32'h2A);
    chk("jal_regWrite", regWrite, 1);

    issue(1, 6'h00, 0, 1, 0, 0, 0, 32'h5555, 0, 0, 0, 0);
    chk("r0_regWrite", regWrite, 0);
    chk("r0_fwd", fwd_valid, 0);
    chk("r0_count", retireCount, 6);

    issue(1, 6'h23, 4, 1, 1, 2'b10, 0, 32'h6, 32'hDEAD_BEEF, 0, 0, 0);
    chk("mis_flag", misaligned, 1);
    chk("mis_regWrite", regWrite, 0);
    issue(1, 6'h23, 4, 1, 1, 2'b11, 0, 32'h4, 32'hDEAD_BEEF, 0, 0, 0);
    chk("align_flag", misaligned, 0);
    chk("align_data", writeData, 32'hDEAD_BEEF);
    chk("align_regWrite", regWrite, 1);

    issue(1, 6'h00, 3, 1, 0, 0, 0, 32'h55, 0, 0, 0, 0);
    chk("hold0_regWrite", regWrite, 1);
    chk("hold0_fwd", fwd_valid, 1);
    for (int i = 0; i < 3; i++) begin
      issue(1, 6'h00, 4, 1, 0, 0, 0, 32'h99, 0, 0, 1, 1);
      chk("hold_regWrite", regWrite, 0);
      chk("hold_fwd", fwd_valid, 1);
      chk("hold_data", writeData, 32'h55);
      chk("hold_count", retireCount, 9);
    end

    issue(1, 6'h00, 4, 1, 0, 0, 0, 32'h99, 0, 0, 0, 1);
    chk("flush_regWrite", regWrite, 0);
    chk("flush_fwd", fwd_valid, 0);
    chk("flush_count", retireCount, 9);

    reset = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 17; i++)
      issue(1, 6'h00, 5'(i + 1), 1, 0, 0, 0, 32'(i * 3), 0, 0, 0, 0);
    chk("wrap_count", retireCount, 1);

    issue(1, 6'h00, 6, 1, 0, 0, 0, 32'h77, 0, 0, 0, 0);
    issue(1, 6'h00, 6, 1, 0, 0, 0, 32'h77, 0, 0, 1, 0);
    #2 reset = 1'b0;
    #1 allZero("async_reset");
    @(posedge clock);
    #1 reset = 1'b1;
    issue(1, 6'h00, 8, 1, 0, 0, 0, 32'h88, 0, 0, 0, 0);
    chk("post_reset_regWrite", regWrite, 1);
    chk("post_reset_addr", writeAddr, 8);
    chk("post_reset_count", retireCount, 1);

    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage and the write-side counterpart of the decode stage's register-file reads.
- Latches the MEM/WB pipeline register and selects the result: ALU result, lane-extracted load data, or jal link address.
- Drives the register file write port (regWrite/writeAddr/writeData).
- Also exports a forwarding copy of the write, a misalignment flag, and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- PC_W, 7, instruction address width (matches jump/jr address width)
- COUNT_W, 16, retire counter width
- LINK_REG, 31, destination register for jal

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- mem_valid  input  1  MEM stage holds a real instruction
- mem_opCode  input  6  opcode; 6'h03 = jal
- mem_rd  input  ADDR_W  destination register
- mem_regWrite  input  1  instruction writes a register
- mem_memToReg  input  1  result comes from load data
- mem_loadSize  input  2  00 byte, 01 half, 10 word
- mem_loadSigned  input  1  sign-extend sub-word loads
- mem_aluResult  input  DATA_W  ALU result / load byte address
- mem_loadData  input  DATA_W  aligned 32-bit memory word
- mem_linkAddr  input  PC_W  return address (PC+1) for jal
- hold  input  1  WB retains its current entry
- flush  input  1  discard the incoming MEM entry
- regWrite  output  1  register file write enable
- writeAddr  output  ADDR_W  register file write address
- writeData  output  DATA_W  register file write data
- fwd_valid  output  1  writeData is forwardable to decode/execute
- misaligned  output  1  captured load was misaligned
- retireCount  output  COUNT_W  retired-instruction count

Behaviour:
- Reset (reset=0, asynchronous) clears all state:
  - regWrite=0, writeAddr=0, writeData=0, fwd_valid=0, misaligned=0, retireCount=0.
  - Internal valid=0, written=1.
- Capture happens on the clock edge when hold=0:
  - Entry valid <= mem_valid & ~flush.
  - Result, address and flags are computed combinationally from the MEM inputs and registered.
  - Latency is 1 cycle from the MEM inputs to the write port.
  - written <= 0.
- Result selection, in priority order:
  1. jal (opcode 6'h03): writeAddr=LINK_REG, writeData={zeros, mem_linkAddr}.
  2. mem_memToReg: extract the load lane, then extend.
  3. Otherwise: writeAddr=mem_rd, writeData=mem_aluResult.
- Load extraction:
  - Byte: lane = aluResult[1:0], lane 0 = bits 7:0.
  - Half: aluResult[1] selects bits 31:16 vs 15:0.
  - Word: data passes through.
  - Sub-word results are sign-extended if mem_loadSigned, else zero-extended.
- Misalignment:
  - Half with aluResult[0]=1, or word with aluResult[1:0]!=0, sets misaligned=1 for that entry.
  - The register write is suppressed for that entry.
  - loadSize=11 is treated as word.
- regWrite = valid & ~written & (mem_regWrite or jal) & ~misaligned & writeAddr!=0.
  - Writes to r0 are never issued.
- Hold:
  - With hold=1 the entry is retained.
  - regWrite asserts only in the first cycle the entry is present; `written` is set at the first edge after capture, so hold never repeats a write.
  - fwd_valid stays at valid & (result-writing) & ~misaligned & writeAddr!=0 for the whole hold.
  - hold has priority over flush: while hold=1, flush is ignored and incoming MEM inputs are not sampled.
- Retire counter:
  - Increments by 1 at each capture edge where the incoming entry is valid (mem_valid & ~flush & ~hold).
  - Misaligned and non-writing instructions are still counted.
  - Wraps from 2^COUNT_W-1 to 0.
- Bubble: when valid=0, regWrite=0, fwd_valid=0 and misaligned=0; writeAddr/writeData are don't-care but held.
- Reset mid-hold: the entry is lost, outputs return to reset values, and the first edge after deassertion captures normally.

Test Plan:
- After reset, MEM: valid=1, regWrite=1, rd=5, aluResult=32'h0000_1234 -> next cycle regWrite=1, writeAddr=5, writeData=32'h1234, retireCount=1.
- Load byte: loadData=32'h80FF_7F01, aluResult[1:0]=3, signed=1 -> writeData=32'hFFFF_FF80; same with signed=0 -> 32'h0000_0080; half, aluResult=2, signed=1 -> 32'hFFFF_80FF.
- jal: opCode=6'h03, linkAddr=7'h2A, rd=9 -> writeAddr=31, writeData=32'h2A; rd=0 with a normal ALU op -> regWrite=0, fwd_valid=0, counter still increments.
- Misaligned word load, aluResult=32'h6 -> misaligned=1, regWrite=0; next aligned instruction clears misaligned.
- hold=1 for 3 cycles after a capture -> regWrite high only in the first cycle, fwd_valid high all 4 cycles, retireCount unchanged; flush=1 with mem_valid=1 and hold=0 -> bubble, counter unchanged.
- COUNT_W=4, 17 valid instructions -> retireCount=1; assert reset mid-hold -> all outputs 0 immediately, without waiting for a clock edge.
